// File: rtl/mc_main_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state encodings,
// opcode constants, datapath select codes and the bundled control-word type.
package mc_main_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ      = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_HALT     = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // One control word per cycle; all-zero is the idle/safe value.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    // States that wait on the memory handshake and are covered by the timeout.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode and memory ready in, control word,
// status and debug state out. master = controller side, slave = datapath side.
interface mc_main_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal_op, mem_timeout, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal_op, mem_timeout, state_dbg
    );
endinterface

// File: rtl/mc_mem_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles of a memory state,
// flags expire once the count reaches LIMIT-1.
module mc_mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expire
);
    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt_reg;

    assign expire = (cnt_reg == W'(LIMIT - 1));

    // Count while not cleared; hold at the limit so the count never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (!expire) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS core.
// Optional feature: define MC_MAIN_CTRL_ADDI_EN to build the addi path
// (ADDI_EX/ADDI_WB); otherwise opcode 001000 decodes as illegal.
module mc_main_ctrl
    import mc_main_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_main_ctrl_if.master bus
);
    state_e state_reg, state_next;
    ctrl_t  ctrl;
    logic   mem_timeout_reg;
    logic   in_mem, wait_clr, expire, timeout_hit;

    assign in_mem      = is_mem_state(state_reg);
    assign wait_clr    = !in_mem || bus.mem_ready;
    assign timeout_hit = in_mem && !bus.mem_ready && expire;

    mc_mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wait_clr),
        .expire (expire)
    );

    // State register and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_RST;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (timeout_hit) begin
                mem_timeout_reg <= 1'b1;
            end
        end
    end

    // Next-state and Moore output decode (FETCH writes gated by mem_ready).
    always_comb begin
        state_next = state_reg;
        ctrl       = '0;
        case (state_reg)
            S_RST: state_next = S_FETCH;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = S_DECODE;
                end else if (expire) begin
                    state_next = S_HALT;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPE_EX;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_J:         state_next = S_JUMP;
`ifdef MC_MAIN_CTRL_ADDI_EN
                    OP_ADDI:      state_next = S_ADDI_EX;
`endif
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        state_next      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_next     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready)  state_next = S_MEMWB;
                else if (expire)    state_next = S_HALT;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_next      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (bus.mem_ready)  state_next = S_FETCH;
                else if (expire)    state_next = S_HALT;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_next     = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_next     = S_FETCH;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                state_next         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_next     = S_FETCH;
            end
`ifdef MC_MAIN_CTRL_ADDI_EN
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_next     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_next     = S_FETCH;
            end
`endif
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.mem_timeout   = mem_timeout_reg;
    assign bus.state_dbg     = state_reg;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl (MEM_TIMEOUT=4). The driver walks each
// instruction through its micro-steps and pushes the expected per-cycle
// control word; a negedge monitor pops and compares.
// Honors MC_MAIN_CTRL_ADDI_EN the same way the design does.
module tb_mc_main_ctrl;
    import mc_main_ctrl_pkg::*;

    localparam int MT = 4;
`ifdef MC_MAIN_CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       mem_timeout;
        logic [3:0] state;
    } exp_t;

    typedef struct {
        exp_t  v;
        string tag;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    item_t sb_q[$];
    int checks_total  = 0;
    int checks_passed = 0;
    int cyc_in_instr  = 0;

    mc_main_ctrl_if bus ();

    mc_main_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected control word of one micro-step, straight from the step table.
    function automatic exp_t expect_step(input state_e s, input logic rdy,
                                         input logic ill, input logic tmo);
        exp_t e;
        e = '0;
        e.state       = s;
        e.mem_timeout = tmo;
        case (s)
            S_FETCH:    begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            S_DECODE:   begin e.alu_src_b = 2'b11; e.illegal_op = ill; end
            S_MEMADR:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_MEMRD:    begin e.mem_read = 1; e.i_or_d = 1; end
            S_MEMWB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
            S_MEMWR:    begin e.mem_write = 1; e.i_or_d = 1; end
            S_RTYPE_EX: begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            S_RTYPE_WB: begin e.reg_write = 1; e.reg_dst = 1; end
            S_BEQ:      begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            S_JUMP:     begin e.pc_write = 1; e.pc_source = 2'b10; end
            S_ADDI_EX:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_ADDI_WB:  begin e.reg_write = 1; end
            default:    ;
        endcase
        return e;
    endfunction

    // Drive mem_ready for one cycle and record the expected outputs of that cycle.
    task automatic step(input logic rdy, input exp_t e, input string tag);
        item_t it;
        bus.mem_ready = rdy;
        it.v   = e;
        it.tag = tag;
        sb_q.push_back(it);
        cyc_in_instr++;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_step(input state_e s, input string tag);
        step(1'($urandom_range(0, 1)), expect_step(s, 1'b0, 1'b0, 1'b0), tag);
    endtask

    // A memory state: 'waits' not-ready cycles then the ready cycle.
    task automatic mem_phase(input state_e s, input int waits, input string tag);
        for (int i = 0; i < waits; i++) step(1'b0, expect_step(s, 1'b0, 1'b0, 1'b0), tag);
        step(1'b1, expect_step(s, 1'b1, 1'b0, 1'b0), tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'($urandom_range(0, 1)), expect_step(S_RST, 1'b0, 1'b0, 1'b0), "reset");
        step(1'($urandom_range(0, 1)), expect_step(S_RST, 1'b0, 1'b0, 1'b0), "reset");
        rst_n = 1'b1;
        step(1'($urandom_range(0, 1)), expect_step(S_RST, 1'b0, 1'b0, 1'b0), "reset_release");
        $display("txn reset");
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010) || (ADDI_EN && op == 6'b001000);
    endfunction

    // One full instruction from FETCH through its last step.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        logic ill;
        cyc_in_instr = 0;
        bus.opcode = op;
        ill = !is_legal(op);
        mem_phase(S_FETCH, fw, "fetch");
        step(1'($urandom_range(0, 1)), expect_step(S_DECODE, 1'b0, ill, 1'b0), "decode");
        if (!ill) begin
            case (op)
                6'b100011: begin
                    rnd_step(S_MEMADR, "lw_memadr");
                    mem_phase(S_MEMRD, mw, "lw_memrd");
                    rnd_step(S_MEMWB, "lw_memwb");
                end
                6'b101011: begin
                    rnd_step(S_MEMADR, "sw_memadr");
                    mem_phase(S_MEMWR, mw, "sw_memwr");
                end
                6'b000000: begin
                    rnd_step(S_RTYPE_EX, "rtype_ex");
                    rnd_step(S_RTYPE_WB, "rtype_wb");
                end
                6'b000100: rnd_step(S_BEQ, "beq");
                6'b000010: rnd_step(S_JUMP, "jump");
                default: begin
                    rnd_step(S_ADDI_EX, "addi_ex");
                    rnd_step(S_ADDI_WB, "addi_wb");
                end
            endcase
        end
        $display("txn op=%b fetch_wait=%0d mem_wait=%0d illegal=%0b cycles=%0d",
                 op, fw, mw, ill, cyc_in_instr);
    endtask

    // Memory state left without ready for MT cycles, then parked in HALT.
    task automatic timeout_in(input state_e s, input string tag);
        for (int i = 0; i < MT; i++) step(1'b0, expect_step(s, 1'b0, 1'b0, 1'b0), tag);
        for (int i = 0; i < 3; i++) rnd_step_halt();
        $display("txn timeout in %s", tag);
    endtask

    task automatic rnd_step_halt();
        step(1'($urandom_range(0, 1)), expect_step(S_HALT, 1'b0, 1'b0, 1'b1), "halt");
    endtask

    // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
    exp_t  mon_act;
    item_t mon_item;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_item = sb_q.pop_front();
            mon_act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                       bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                       bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                       bus.alu_op, bus.illegal_op, bus.mem_timeout, bus.state_dbg};
            checks_total++;
            if (mon_act === mon_item.v) checks_passed++;
            else $display("FAIL %s: got %h expected %h (time %0t)",
                          mon_item.tag, mon_act, mon_item.v, $time);
        end
    end

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
        ops[6] = 6'b111111;
        rst_n = 1'b0;
        bus.opcode = 6'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed cases.
        run_instr(6'b000000, 0, 0);
        run_instr(6'b100011, 0, 3);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b000000, MT - 1, 0);   // ready in the limit cycle of FETCH
        run_instr(6'b101011, 1, MT - 1);   // ready in the limit cycle of MEMWR

        // FETCH timeout, then recover by reset.
        timeout_in(S_FETCH, "fetch_to");
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            op = (n % 8 == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, MT - 1), $urandom_range(0, MT - 1));
        end

        // MEMWR timeout.
        run_instr(6'b000010, 0, 0);
        cyc_in_instr = 0;
        bus.opcode = 6'b101011;
        mem_phase(S_FETCH, 0, "fetch");
        rnd_step(S_DECODE, "decode");
        rnd_step(S_MEMADR, "sw_memadr");
        timeout_in(S_MEMWR, "memwr_to");
        do_reset();

        // Reset in the middle of a MEMWR wait aborts the access at once.
        run_instr(6'b000000, 0, 0);
        bus.opcode = 6'b101011;
        mem_phase(S_FETCH, 0, "fetch");
        rnd_step(S_DECODE, "decode");
        rnd_step(S_MEMADR, "sw_memadr");
        step(1'b0, expect_step(S_MEMWR, 1'b0, 1'b0, 1'b0), "sw_memwr");
        do_reset();
        run_instr(6'b100011, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks_total++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
